// File: rtl/tick_pkg.sv
// Shared definitions for the multi-channel tick generator: mode encodings,
// one-shot FSM states and elaboration-time sizing helpers.
package tick_pkg;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_PER = 2'b01;
  localparam logic [1:0] MODE_ONE = 2'b10;

  typedef enum logic {
    OS_IDLE = 1'b0,
    OS_RUN  = 1'b1
  } os_state_e;

  function automatic int tick_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int tick_ch_w(input int n_ch);
    return (n_ch <= 1) ? 1 : tick_clog2(n_ch);
  endfunction

  function automatic int tick_default_div(input int freq_clk, input int freq_wanted);
    return freq_clk / freq_wanted;
  endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// Configuration, trigger and tick bundle of the multi-channel tick generator.
// The master drives configuration and triggers; the slave returns ticks.
interface tick_gen_multi_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 16
);
  localparam int CH_W = tick_pkg::tick_ch_w(N_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_mode;
  logic             cfg_restart;
  logic [N_CH-1:0]  start;
  logic             sync;
  logic [N_CH-1:0]  pulse;
  logic [N_CH-1:0]  busy;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_mode, cfg_restart, start, sync,
    input  pulse, busy
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_mode, cfg_restart, start, sync,
    output pulse, busy
  );

endinterface

// File: rtl/tick_channel.sv
// One tick channel: wrapping counter, shadowed divider applied at wrap,
// and a one-shot IDLE/RUN FSM.
module tick_channel
  import tick_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 2500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [1:0]       mode_i,
  input  logic             restart_i,
  input  logic             start_i,
  input  logic             sync_i,
  output logic             pulse_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO_V     = DIV_W'(2);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_shd_q, div_shd_d;
  logic [1:0]       mode_q, mode_d;
  logic             pulse_q, pulse_d;
  os_state_e        os_q, os_d;

  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] last_cnt;
  logic             is_per;
  logic             is_one;
  logic             running;
  logic             wrap;
  logic             hard_cfg;

  // Dividers 0 and 1 both mean "tick every cycle".
  assign eff_div  = (div_act_q < TWO_V) ? ONE_V : div_act_q;
  assign last_cnt = eff_div - ONE_V;
  assign is_per   = (mode_q == MODE_PER);
  assign is_one   = (mode_q == MODE_ONE);
  assign wrap     = running && (cnt_q == last_cnt);
  assign hard_cfg = we_i && (restart_i || (mode_i != mode_q));

  // One-shot FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_q <= OS_IDLE;
    end else begin
      os_q <= os_d;
    end
  end

  // One-shot FSM: next state
  always_comb begin
    os_d = os_q;
    if (!is_one || hard_cfg) begin
      os_d = OS_IDLE;
    end else begin
      case (os_q)
        OS_IDLE: if (start_i) os_d = OS_RUN;
        OS_RUN:  if (wrap)    os_d = OS_IDLE;
        default:              os_d = OS_IDLE;
      endcase
    end
  end

  // One-shot FSM: outputs
  always_comb begin
    running = is_per || (is_one && (os_q == OS_RUN));
    busy_o  = running;
  end

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    mode_d    = mode_q;
    pulse_d   = 1'b0;
    if (we_i) begin
      div_shd_d = div_i;
      mode_d    = mode_i;
    end
    if (hard_cfg) begin
      cnt_d     = '0;
      div_act_d = div_i;
    end else if (sync_i && is_per) begin
      cnt_d = '0;
    end else if (wrap) begin
      // A write landing on the wrap cycle bypasses the shadow register.
      cnt_d     = '0;
      pulse_d   = 1'b1;
      div_act_d = we_i ? div_i : div_shd_q;
    end else if (running) begin
      cnt_d = cnt_q + ONE_V;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      div_act_q <= DEF_DIV_V;
      div_shd_q <= DEF_DIV_V;
      mode_q    <= MODE_PER;
      pulse_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      mode_q    <= mode_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: decodes the configuration
// target and fans the shared sync out to N_CH independent channels.
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int FREQ_CLK    = 50000000,
  parameter int FREQ_WANTED = 20000,
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  tick_gen_multi_if.slave  bus
);

  localparam int DEFAULT_DIV = tick_default_div(FREQ_CLK, FREQ_WANTED);
  localparam int CH_W        = tick_ch_w(N_CH);

  logic [N_CH-1:0] ch_we;
  logic [N_CH-1:0] pulse_w;
  logic [N_CH-1:0] busy_w;

  // Selects outside 0..N_CH-1 match no channel, so such writes are dropped.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_we[gi] = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

      tick_channel #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .we_i      (ch_we[gi]),
        .div_i     (bus.cfg_div),
        .mode_i    (bus.cfg_mode),
        .restart_i (bus.cfg_restart),
        .start_i   (bus.start[gi]),
        .sync_i    (bus.sync),
        .pulse_o   (pulse_w[gi]),
        .busy_o    (busy_w[gi])
      );
    end
  endgenerate

  assign bus.pulse = pulse_w;
  assign bus.busy  = busy_w;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi with DEFAULT_DIV=5, four channels.
module tb_tick_gen_multi;
  import tick_pkg::*;

  localparam int N_CH  = 4;
  localparam int DIV_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tick_gen_multi_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

  tick_gen_multi #(
    .FREQ_CLK    (100),
    .FREQ_WANTED (20),
    .N_CH        (N_CH),
    .DIV_W       (DIV_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int    e;
    int    ch;
    logic  p;
    logic  b;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   exp_hi[$];
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;

  // Rising edges since reset release; 0 while reset is held.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) edge_n = 0;
      else       edge_n = edge_n + 1;
    end
  end

  // Monitor: sample after edge edge_n and retire every check due now.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].e <= edge_n) begin
          total = total + 1;
          if (sb[i].e < edge_n) begin
            bad = bad + 1;
            $display("FAIL %s ch%0d edge%0d: not sampled, now at edge %0d",
                     sb[i].nm, sb[i].ch, sb[i].e, edge_n);
          end else if (bus.pulse[sb[i].ch] !== sb[i].p || bus.busy[sb[i].ch] !== sb[i].b) begin
            bad = bad + 1;
            $display("FAIL %s ch%0d edge%0d: got pulse=%b busy=%b, want pulse=%b busy=%b",
                     sb[i].nm, sb[i].ch, sb[i].e, bus.pulse[sb[i].ch], bus.busy[sb[i].ch],
                     sb[i].p, sb[i].b);
          end else begin
            $display("ok   %s ch%0d edge%0d pulse=%b busy=%b",
                     sb[i].nm, sb[i].ch, sb[i].e, sb[i].p, sb[i].b);
          end
          sb.delete(i);
        end
      end
    end
  end

  // Push per-edge expectations for one channel; pulse edges come from exp_hi.
  task automatic exp_win(input int ch, input int a, input int b,
                         input int bf, input int bt, input string nm);
    logic p;
    for (int e = a; e <= b; e++) begin
      p = 1'b0;
      foreach (exp_hi[k]) if (exp_hi[k] == e) p = 1'b1;
      sb.push_back('{e: e, ch: ch, p: p, b: (e >= bf && e <= bt), nm: nm});
    end
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input int at, input int ch, input int dv,
                           input logic [1:0] md, input logic rs);
    wait_edge(at - 1);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = 2'(ch);
    bus.cfg_div     = 8'(dv);
    bus.cfg_mode    = md;
    bus.cfg_restart = rs;
    wait_edge(at);
    bus.cfg_we      = 1'b0;
    bus.cfg_restart = 1'b0;
  endtask

  task automatic start_at(input int at, input logic [N_CH-1:0] m);
    wait_edge(at - 1);
    bus.start = m;
    wait_edge(at);
    bus.start = '0;
  endtask

  task automatic sync_at(input int at);
    wait_edge(at - 1);
    bus.sync = 1'b1;
    wait_edge(at);
    bus.sync = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    for (int c = 0; c < N_CH; c++)
      sb.push_back('{e: 0, ch: c, p: 1'b0, b: 1'b1, nm: "reset"});
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n = n + 1;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d checks still pending, want 0", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
  endtask

  initial begin
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_div     = '0;
    bus.cfg_mode    = MODE_OFF;
    bus.cfg_restart = 1'b0;
    bus.start       = '0;
    bus.sync        = 1'b0;

    // Default cadence from reset
    do_reset();
    exp_hi = '{5, 10, 15};
    for (int c = 0; c < N_CH; c++) exp_win(c, 1, 16, 1, 16, "default");
    drain();

    // Shadowed divider on ch1: current period finishes first
    do_reset();
    exp_hi = '{5, 10, 13, 16, 19, 22};
    exp_win(1, 1, 23, 1, 23, "shadow");
    exp_hi = '{5, 10, 15, 20};
    exp_win(0, 1, 23, 1, 23, "neighbour");
    exp_win(2, 1, 23, 1, 23, "neighbour");
    exp_win(3, 1, 23, 1, 23, "neighbour");
    cfg_write(7, 1, 3, MODE_PER, 1'b0);
    drain();

    // One-shot on ch2 with a retrigger ignored during RUN
    do_reset();
    exp_hi = '{};
    exp_win(2, 1, 1, 1, 1, "os_pre");
    exp_hi = '{9};
    exp_win(2, 2, 13, 5, 8, "os_run1");
    exp_hi = '{18};
    exp_win(2, 14, 22, 14, 17, "os_run2");
    exp_hi = '{5, 10, 15, 20};
    exp_win(0, 1, 22, 1, 22, "os_other");
    cfg_write(2, 2, 4, MODE_ONE, 1'b0);
    start_at(5, 4'b0100);
    start_at(7, 4'b0100);
    start_at(14, 4'b0100);
    drain();

    // Restart on ch3 aborts the running period
    do_reset();
    exp_hi = '{11, 18, 25};
    exp_win(3, 1, 26, 1, 26, "restart");
    exp_hi = '{5, 10, 15, 20, 25};
    exp_win(0, 1, 26, 1, 26, "rs_other");
    cfg_write(4, 3, 7, MODE_PER, 1'b1);
    drain();

    // sync with ch1 OFF and ch2 one-shot running
    do_reset();
    exp_hi = '{5, 13, 18};
    exp_win(0, 1, 20, 1, 20, "sync_per");
    exp_win(3, 1, 20, 1, 20, "sync_per");
    exp_hi = '{};
    exp_win(1, 1, 20, -1, -1, "sync_off");
    exp_win(2, 1, 1, 1, 1, "sync_os_pre");
    exp_hi = '{10};
    exp_win(2, 2, 20, 6, 9, "sync_os");
    cfg_write(1, 1, 5, MODE_OFF, 1'b0);
    cfg_write(2, 2, 4, MODE_ONE, 1'b0);
    start_at(3, 4'b0010);
    start_at(6, 4'b0100);
    sync_at(8);
    drain();

    // Divider 0 on ch0, then an asynchronous reset mid-cycle
    do_reset();
    exp_hi = '{5, 6, 7, 8, 9, 10, 11};
    exp_win(0, 1, 11, 1, 11, "div0");
    exp_hi = '{5, 10};
    for (int c = 1; c < N_CH; c++) exp_win(c, 1, 11, 1, 11, "div0_other");
    cfg_write(2, 0, 0, MODE_PER, 1'b0);
    wait_edge(12);
    do_reset();
    exp_hi = '{5, 10, 15};
    for (int c = 0; c < N_CH; c++) exp_win(c, 1, 16, 1, 16, "post_reset");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Multi-channel, runtime-programmable successor to the single fixed-rate tick generator.
- Each of N_CH channels produces single-cycle pulses every DIV clock cycles.
- Each channel runs in periodic or one-shot mode. Divider changes are glitch-free (shadowed, applied at wrap).
- Sits beside the system clock and feeds timing strobes (sample rates, PWM bases, timeouts) to downstream units.

Parameters:
- FREQ_CLK, 50000000, input clock frequency in Hz.
- FREQ_WANTED, 20000, reset-default tick rate for every channel.
- N_CH, 4, number of channels (1..16).
- DIV_W, 16, divider/counter width in bits; DEFAULT_DIV must fit.
- Derived localparam DEFAULT_DIV = FREQ_CLK/FREQ_WANTED (integer division), = 2500 at the defaults.
- Derived localparam CH_W = max(1, clog2(N_CH)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_div  in  DIV_W  new divider value.
- cfg_mode  in  2  00 OFF, 01 PERIODIC, 10 ONESHOT, 11 reserved (treated as OFF).
- cfg_restart  in  1  with cfg_we: apply cfg_div immediately and clear the counter.
- start  in  N_CH  per-channel one-shot trigger, level sampled per cycle.
- sync  in  1  clears the counters of all PERIODIC channels in the same cycle.
- pulse  out  N_CH  registered single-cycle tick per channel.
- busy  out  N_CH  channel counter is running.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset state, per channel: cnt=0, div_act=div_shd=DEFAULT_DIV, mode=PERIODIC, pulse=0, busy=1 (periodic channels run from reset).
- Counter: cnt counts 0..div_act-1 and wraps to 0. wrap = running && cnt==div_act-1.
- Pulse timing: pulse[i] <= wrap (registered). The first pulse is high in the cycle after rising edge number div_act following reset release; pulses then repeat every div_act cycles.
- Divider 0 or 1: the effective divider is 1, so in PERIODIC mode pulse stays high continuously.
- Config write (cfg_we, cfg_ch<N_CH): div_shd <= cfg_div and mode <= cfg_mode.
  - cfg_ch >= N_CH: the write is ignored.
  - A mode change clears cnt and loads div_act <= cfg_div immediately.
- Divider update without restart: div_act <= div_shd at the next wrap.
  - If the write lands in the wrap cycle itself, cfg_div bypasses into div_act at that wrap.
  - The running period is never truncated.
- cfg_restart=1: cnt <= 0 and div_act <= cfg_div in the same edge; no pulse is emitted for the aborted period.
- OFF mode: cnt held at 0, pulse=0, busy=0; start is ignored.
- ONESHOT mode:
  - States: IDLE -> RUN on start[i]; RUN -> IDLE on wrap (one pulse emitted).
  - busy=1 only in RUN. start during RUN is ignored.
  - Entering ONESHOT via a config write lands in IDLE.
- sync: cnt <= 0 on PERIODIC channels only; div_act is unchanged; no pulse is generated by the sync itself.
- Priority per channel: reset > config write to this channel (restart or mode change) > sync > normal count/wrap.
- Channels are fully independent apart from sync. Writing one channel never disturbs another.
- Arithmetic: cnt is DIV_W bits unsigned, compared against div_act-1 with div_act clamped to >=1. There is no overflow path.
- Reset asserted mid-period: everything returns to the reset state asynchronously. The first pulse again follows after DEFAULT_DIV cycles.

Decomposition:
- Package tick_pkg holds:
  - mode encodings (MODE_OFF, MODE_PER, MODE_ONE);
  - the clog2 constant function;
  - the DEFAULT_DIV computation helper.
- Sub-module tick_channel (one counter, shadow register, one-shot FSM) is instantiated N_CH times by a generate loop.
- The top level holds only cfg_ch decode and sync fan-out.

Test Plan (bench params FREQ_CLK=100, FREQ_WANTED=20 -> DEFAULT_DIV=5, N_CH=4, DIV_W=8):
- Release reset, idle inputs -> every pulse[i] high after edges 5, 10, 15; busy=4'b1111.
- Write ch1 div=3 mid-period, no restart -> ch1 finishes the current 5-cycle period, then pulses every 3 cycles; other channels unchanged.
- Write ch2 mode=ONESHOT div=4, then start[2] pulse -> busy[2] high 4 cycles, exactly one pulse[2], then idle; a second start during RUN has no effect.
- Write ch3 div=7 with cfg_restart at cnt=3 -> no pulse for the aborted period; next pulse[3] 7 cycles after the write.
- Assert sync when ch0 cnt=2 -> ch0 next pulse 5 cycles after sync; a OFF/ONESHOT channel is unaffected.
- Write div=0 to ch0 -> pulse[0] stays high continuously. Assert reset asynchronously mid-cycle -> pulse=0 immediately; 5-cycle cadence resumes after release.
